delay_timer: RTL and testbench
==============================

DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 7, counter width in bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent delay channels.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port trigger  input  CHANNELS  per-channel trigger level; bit i drives channel i.
REQ-006 SHALL have port n  input  CHANNELS*WIDTH  per-channel delay in cycles; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port mode  input  2*CHANNELS  per-channel mode; channel i at bits [2i +: 2].
REQ-008 SHALL have port time_out  output  CHANNELS  per-channel one-cycle fire pulse, registered.
REQ-009 SHALL have port busy  output  CHANNELS  per-channel high whenever channel state is not IDLE.

Function
REQ-010 Channels SHALL be fully independent; no shared state except clk/rst.
REQ-011 Each channel SHALL use states IDLE, COUNTING, FIRE, WAIT_LOW; time_out high only in FIRE.
REQ-012 Trigger event = rising edge: trigger high at a sampling edge while the registered previous trigger is low.
REQ-013 IDLE: on trigger event with n != 0, load count = n-1, enter COUNTING; with n == 0, stay IDLE (channel disabled).
REQ-014 COUNTING: count decrements by 1 per cycle; at count == 0, next state FIRE.
REQ-015 Latency: trigger event sampled at edge k -> time_out high for exactly the cycle following edge k+n.
REQ-016 n and mode SHALL be captured at load; changes during COUNTING/FIRE/WAIT_LOW ignored until next load.
REQ-017 Mode 0 ONESHOT: FIRE -> WAIT_LOW if trigger high, else IDLE; WAIT_LOW -> IDLE when trigger low.
REQ-018 Mode 1 RETRIG: as ONESHOT, plus trigger event during COUNTING reloads count = captured n-1 (restarts delay with newly sampled n).
REQ-019 Mode 2 PERIODIC: FIRE -> COUNTING with count = captured n-1 while trigger high; FIRE -> IDLE if trigger low.
REQ-020 Mode 3 reserved; SHALL behave as ONESHOT.
REQ-021 Trigger event in FIRE SHALL NOT start a new count in ONESHOT/RETRIG; it enters WAIT_LOW.
REQ-022 Counter arithmetic modulo 2^WIDTH; n = 2^WIDTH-1 SHALL give full-range delay without wrap.
REQ-023 Illegal state encoding SHALL return to IDLE next cycle with time_out low.

Reset
REQ-024 rst high SHALL immediately force every channel to IDLE, count 0, captured n/mode 0, time_out 0, busy 0.
REQ-025 Previous-trigger register SHALL reset to 1, so a trigger held high across reset release is not an event.
REQ-026 rst asserted mid-count SHALL abort the count; no time_out pulse SHALL follow.

Configuration
REQ-027 Macro DELAY_TIMER_CANCEL_EN defined: add input cancel, width CHANNELS; cancel[i] high at an edge forces channel i to IDLE, overrides trigger and FIRE, time_out low next cycle.
REQ-028 Macro DELAY_TIMER_CANCEL_EN undefined: cancel port absent; behaviour per REQ-010..026 only.

Structure
REQ-029 Package delay_timer_pkg SHALL hold the state enum (IDLE, COUNTING, FIRE, WAIT_LOW) and mode enum/constants (ONESHOT=0, RETRIG=1, PERIODIC=2).
REQ-030 Per-channel logic SHALL be sub-module delay_channel (parameter WIDTH), instantiated CHANNELS times via generate.

Verification
REQ-031 ONESHOT, n=5, trigger pulse 1 cycle at edge 10 -> time_out high only in cycle after edge 15; busy high edges 10..15.
REQ-032 ONESHOT, n=3, trigger held high 20 cycles -> exactly one pulse, channel in WAIT_LOW until trigger low, then IDLE.
REQ-033 RETRIG, n=8, second trigger event 4 cycles after first -> single pulse 8 cycles after second event.
REQ-034 PERIODIC, n=4, trigger held high 17 cycles -> pulses every 5 cycles (4 count + 1 FIRE), stop after trigger low.
REQ-035 n=0 with trigger events -> no pulse, busy stays 0; channels 0 and 3 triggered simultaneously with n=2, n=6 -> independent pulses at +2, +6.
REQ-036 rst asserted asynchronously mid-count (n=10, after 4 cycles) -> outputs 0 immediately, no later pulse; with DELAY_TIMER_CANCEL_EN, cancel at same point -> identical result.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// -----------------------------------------------------------------------------
// delay_timer_pkg
// Shared types for the multi-channel delay timer.
//   state_t : per-channel FSM states (IDLE, COUNTING, FIRE, WAIT_LOW)
//   mode_t  : per-channel operating mode (ONESHOT, RETRIG, PERIODIC, reserved)
// Helper functions classify a captured mode so the channel FSM reads cleanly.
// -----------------------------------------------------------------------------
package delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        FIRE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ONESHOT   = 2'd0,
        RETRIG    = 2'd1,
        PERIODIC  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    // Only PERIODIC re-arms from FIRE; the reserved code falls back to one-shot.
    function automatic logic is_periodic(input mode_t m);
        return (m == PERIODIC);
    endfunction

    // Only RETRIG lets a fresh trigger event restart a running count.
    function automatic logic is_retrig(input mode_t m);
        return (m == RETRIG);
    endfunction

endpackage

// File: rtl/delay_timer_channel.sv
// -----------------------------------------------------------------------------
// delay_channel
// One independent delay channel: a rising edge on trigger starts an n-cycle
// delay, after which time_out pulses for exactly one cycle.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous active-high reset
//   trigger  : trigger level; events are detected on its rising edge
//   n        : delay in cycles (0 disables the channel), captured at load
//   mode     : operating mode (see delay_timer_pkg::mode_t), captured at load
//   cancel   : (only with DELAY_TIMER_CANCEL_EN) forces the channel to IDLE
//   time_out : registered one-cycle fire pulse, high only while in FIRE
//   busy     : registered, high whenever the channel is not IDLE
// -----------------------------------------------------------------------------
module delay_channel
    import delay_timer_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [WIDTH-1:0] n,
    input  logic [1:0]       mode,
`ifdef DELAY_TIMER_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             time_out,
    output logic             busy
);

    state_t           state_r;
    state_t           state_s;
    state_t           state_nom_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] n_cap_r;
    logic [WIDTH-1:0] n_cap_s;
    mode_t            mode_cap_r;
    mode_t            mode_cap_s;
    logic             trig_prev_r;
    logic             trig_ev_s;
    logic             time_out_r;
    logic             busy_r;

    // Rising-edge detect against the registered previous trigger level.
    assign trig_ev_s = trigger & ~trig_prev_r;

    // Next-state, counter and capture logic.
    always_comb begin
        state_nom_s = state_r;
        count_s     = count_r;
        n_cap_s     = n_cap_r;
        mode_cap_s  = mode_cap_r;
        case (state_r)
            IDLE: begin
                // n == 0 leaves the channel disabled even on a trigger event.
                if (trig_ev_s && (n != {WIDTH{1'b0}})) begin
                    state_nom_s = COUNTING;
                    count_s     = n - WIDTH'(1);
                    n_cap_s     = n;
                    mode_cap_s  = mode_t'(mode);
                end else begin
                    state_nom_s = IDLE;
                end
            end
            COUNTING: begin
                // A retrigger is a fresh load: n and mode are sampled again.
                if (trig_ev_s && is_retrig(mode_cap_r)) begin
                    if (n != {WIDTH{1'b0}}) begin
                        state_nom_s = COUNTING;
                        count_s     = n - WIDTH'(1);
                        n_cap_s     = n;
                        mode_cap_s  = mode_t'(mode);
                    end else begin
                        state_nom_s = IDLE;
                    end
                end else if (count_r == {WIDTH{1'b0}}) begin
                    state_nom_s = FIRE;
                end else begin
                    count_s = count_r - WIDTH'(1);
                end
            end
            FIRE: begin
                if (trigger) begin
                    if (is_periodic(mode_cap_r)) begin
                        state_nom_s = COUNTING;
                        count_s     = n_cap_r - WIDTH'(1);
                    end else begin
                        state_nom_s = WAIT_LOW;
                    end
                end else begin
                    state_nom_s = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!trigger) begin
                    state_nom_s = IDLE;
                end else begin
                    state_nom_s = WAIT_LOW;
                end
            end
            default: begin
                state_nom_s = IDLE;
                count_s     = {WIDTH{1'b0}};
            end
        endcase
    end

`ifdef DELAY_TIMER_CANCEL_EN
    // Cancel wins over every trigger and FIRE transition.
    assign state_s = cancel ? IDLE : state_nom_s;
`else
    // Without cancel the nominal transition is final.
    assign state_s = state_nom_s;
`endif

    // State, counter, capture and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {WIDTH{1'b0}};
            n_cap_r     <= {WIDTH{1'b0}};
            mode_cap_r  <= ONESHOT;
            // Reset to 1 so a trigger held high through reset is not an event.
            trig_prev_r <= 1'b1;
            time_out_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            n_cap_r     <= n_cap_s;
            mode_cap_r  <= mode_cap_s;
            trig_prev_r <= trigger;
            time_out_r  <= (state_s == FIRE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign time_out = time_out_r;
    assign busy     = busy_r;

endmodule

// File: rtl/delay_timer.sv
// -----------------------------------------------------------------------------
// delay_timer
// CHANNELS fully independent delay timers sharing only clk and rst.
// Optional feature macro: DELAY_TIMER_CANCEL_EN adds a per-channel cancel input.
//
// Ports
//   clk      : clock
//   rst      : asynchronous active-high reset
//   trigger  : [CHANNELS]        trigger level, bit i -> channel i
//   n        : [CHANNELS*WIDTH]  delay, channel i at [i*WIDTH +: WIDTH]
//   mode     : [2*CHANNELS]      mode, channel i at [2i +: 2]
//   cancel   : [CHANNELS]        only with DELAY_TIMER_CANCEL_EN
//   time_out : [CHANNELS]        registered one-cycle fire pulse per channel
//   busy     : [CHANNELS]        per-channel not-IDLE indication
// -----------------------------------------------------------------------------
module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS*WIDTH-1:0] n,
    input  logic [2*CHANNELS-1:0]     mode,
`ifdef DELAY_TIMER_CANCEL_EN
    input  logic [CHANNELS-1:0]       cancel,
`endif
    output logic [CHANNELS-1:0]       time_out,
    output logic [CHANNELS-1:0]       busy
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        delay_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .trigger  (trigger[i]),
            .n        (n[i*WIDTH +: WIDTH]),
            .mode     (mode[2*i +: 2]),
`ifdef DELAY_TIMER_CANCEL_EN
            .cancel   (cancel[i]),
`endif
            .time_out (time_out[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_delay_timer.sv
// -----------------------------------------------------------------------------
// tb_delay_timer
// Directed scenarios plus randomized traffic for delay_timer. The reference
// model tracks each channel as a set of flags plus an absolute deadline cycle
// (fire cycle = load cycle + n) and is compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_delay_timer;

    localparam int WIDTH = 7;
    localparam int CH    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [CH-1:0]       trigger = '0;
    logic [CH*WIDTH-1:0] n_bus = '0;
    logic [2*CH-1:0]     mode_bus = '0;
    logic [CH-1:0]       cancel = '0;
    logic [CH-1:0]       time_out;
    logic [CH-1:0]       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state
    bit m_prev  [CH];
    bit m_armed [CH];
    bit m_fire  [CH];
    bit m_wait  [CH];
    int m_deadline [CH];
    int m_n     [CH];
    int m_mode  [CH];

    // watch results
    int w_cnt   [CH];
    int w_first [CH];
    int w_last  [CH];

    delay_timer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trigger  (trigger),
        .n        (n_bus),
        .mode     (mode_bus),
`ifdef DELAY_TIMER_CANCEL_EN
        .cancel   (cancel),
`endif
        .time_out (time_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_prev[i]  = 1'b1;
            m_armed[i] = 1'b0;
            m_fire[i]  = 1'b0;
            m_wait[i]  = 1'b0;
            m_n[i]     = 0;
            m_mode[i]  = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            bit trg;
            bit ev;
            int nv;
            int mv;
            trg = trigger[i];
            ev  = trg && !m_prev[i];
            nv  = int'(n_bus[i*WIDTH +: WIDTH]);
            mv  = int'(mode_bus[2*i +: 2]);
            if (m_fire[i]) begin
                m_fire[i] = 1'b0;
                if (trg && m_mode[i] == 2) begin
                    m_armed[i]    = 1'b1;
                    m_deadline[i] = cyc + m_n[i];
                end else if (trg) begin
                    m_wait[i] = 1'b1;
                end
            end else if (m_armed[i]) begin
                if (ev && m_mode[i] == 1) begin
                    if (nv != 0) begin
                        m_deadline[i] = cyc + nv;
                        m_n[i]        = nv;
                        m_mode[i]     = mv;
                    end else begin
                        m_armed[i] = 1'b0;
                    end
                end else if (cyc == m_deadline[i]) begin
                    m_armed[i] = 1'b0;
                    m_fire[i]  = 1'b1;
                end
            end else if (m_wait[i]) begin
                if (!trg) m_wait[i] = 1'b0;
            end else if (ev && nv != 0) begin
                m_armed[i]    = 1'b1;
                m_deadline[i] = cyc + nv;
                m_n[i]        = nv;
                m_mode[i]     = mv;
            end
`ifdef DELAY_TIMER_CANCEL_EN
            if (cancel[i]) begin
                m_armed[i] = 1'b0;
                m_fire[i]  = 1'b0;
                m_wait[i]  = 1'b0;
            end
`endif
            m_prev[i] = trg;
        end
    endtask

    // One clock: update model at the edge, compare just after it.
    task automatic tick();
        logic [CH-1:0] exp_to;
        logic [CH-1:0] exp_busy;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        for (int i = 0; i < CH; i++) begin
            exp_to[i]   = m_fire[i];
            exp_busy[i] = m_armed[i] | m_fire[i] | m_wait[i];
        end
        check("time_out_vs_model", 64'(time_out), 64'(exp_to));
        check("busy_vs_model", 64'(busy), 64'(exp_busy));
    endtask

    task automatic set_ch(input int ch, input int nv, input int mv);
        n_bus[ch*WIDTH +: WIDTH] = nv[WIDTH-1:0];
        mode_bus[2*ch +: 2]      = mv[1:0];
    endtask

    task automatic reset_dut();
        trigger = '0;
        cancel  = '0;
        rst     = 1'b1;
        #1;
        model_reset();
        check("reset_time_out", 64'(time_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Run len cycles recording pulses per channel; triggers drop before edge drop_at.
    task automatic watch(input int len, input int drop_at);
        for (int i = 0; i < CH; i++) begin
            w_cnt[i] = 0; w_first[i] = -1; w_last[i] = -1;
        end
        for (int j = 1; j <= len; j++) begin
            if (j == drop_at) trigger = '0;
            tick();
            for (int i = 0; i < CH; i++) begin
                if (time_out[i]) begin
                    w_cnt[i]++;
                    if (w_first[i] < 0) w_first[i] = j;
                    w_last[i] = j;
                end
            end
        end
    endtask

    initial begin
        model_reset();

        // Oneshot n=5 single-cycle pulse: fire 5 edges after the event.
        reset_dut();
        set_ch(0, 5, 0);
        trigger[0] = 1'b1;
        tick();
        check("os_busy_after_event", 64'(busy[0]), 64'd1);
        watch(7, 1);
        check("os_pulse_count", 64'(w_cnt[0]), 64'd1);
        check("os_pulse_pos", 64'(w_first[0]), 64'd5);
        check("os_busy_end", 64'(busy[0]), 64'd0);

        // Oneshot n=3 held 20 cycles: one pulse, then WAIT_LOW until release.
        reset_dut();
        set_ch(0, 3, 0);
        trigger[0] = 1'b1;
        tick();
        watch(19, 100);
        check("hold_pulse_count", 64'(w_cnt[0]), 64'd1);
        check("hold_pulse_pos", 64'(w_first[0]), 64'd3);
        check("hold_busy_waitlow", 64'(busy[0]), 64'd1);
        trigger = '0;
        tick();
        check("hold_idle_after_low", 64'(busy[0]), 64'd0);

        // Retrig n=8: second event 4 cycles later restarts the delay.
        reset_dut();
        set_ch(1, 8, 1);
        trigger[1] = 1'b1;
        tick();
        trigger[1] = 1'b0;
        tick(); tick(); tick();
        trigger[1] = 1'b1;
        tick();
        watch(12, 1);
        check("retrig_pulse_count", 64'(w_cnt[1]), 64'd1);
        check("retrig_pulse_pos", 64'(w_first[1]), 64'd8);

        // Periodic n=4 held for edges 0..16: period 5, pending count completes.
        reset_dut();
        set_ch(2, 4, 2);
        trigger[2] = 1'b1;
        tick();
        watch(26, 17);
        check("per_pulse_count", 64'(w_cnt[2]), 64'd4);
        check("per_first", 64'(w_first[2]), 64'd4);
        check("per_last", 64'(w_last[2]), 64'd19);
        check("per_idle_end", 64'(busy[2]), 64'd0);

        // n=0 disables; then channels 0 and 3 run independently.
        reset_dut();
        for (int i = 0; i < CH; i++) set_ch(i, 0, 0);
        trigger = '1;
        tick();
        check("n0_busy", 64'(busy), 64'd0);
        watch(5, 1);
        check("n0_no_pulse", 64'(w_cnt[0] + w_cnt[1] + w_cnt[2] + w_cnt[3]), 64'd0);
        set_ch(0, 2, 0);
        set_ch(3, 6, 0);
        trigger = 4'b1001;
        tick();
        watch(8, 1);
        check("indep_ch0_pos", 64'(w_first[0]), 64'd2);
        check("indep_ch3_pos", 64'(w_first[3]), 64'd6);
        check("indep_ch1_quiet", 64'(w_cnt[1]), 64'd0);

        // Full-range delay n=127 must not wrap.
        reset_dut();
        set_ch(1, 127, 0);
        trigger[1] = 1'b1;
        tick();
        watch(130, 1);
        check("full_range_count", 64'(w_cnt[1]), 64'd1);
        check("full_range_pos", 64'(w_first[1]), 64'd127);

        // Async reset mid-count aborts without a later pulse.
        reset_dut();
        set_ch(0, 10, 0);
        trigger[0] = 1'b1;
        tick();
        watch(4, 1);
        check("abort_busy_before", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_rst_time_out", 64'(time_out), 64'd0);
        check("abort_rst_busy", 64'(busy), 64'd0);
        model_reset();
        #2;
        rst = 1'b0;
        watch(15, 1);
        check("abort_no_pulse", 64'(w_cnt[0]), 64'd0);

`ifdef DELAY_TIMER_CANCEL_EN
        // Cancel at the same point gives the same outcome.
        reset_dut();
        set_ch(0, 10, 0);
        trigger[0] = 1'b1;
        tick();
        watch(4, 1);
        cancel[0] = 1'b1;
        tick();
        cancel[0] = 1'b0;
        check("cancel_busy", 64'(busy[0]), 64'd0);
        check("cancel_time_out", 64'(time_out[0]), 64'd0);
        watch(15, 100);
        check("cancel_no_pulse", 64'(w_cnt[0]), 64'd0);
`endif

        // Randomized traffic with occasional resets.
        reset_dut();
        for (int i = 0; i < CH; i++) set_ch(i, $urandom_range(1, 9), $urandom_range(0, 3));
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) trigger[i] = ~trigger[i];
                if ($urandom_range(0, 11) == 0)
                    set_ch(i, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12),
                           $urandom_range(0, 3));
`ifdef DELAY_TIMER_CANCEL_EN
                cancel[i] = ($urandom_range(0, 59) == 0);
`endif
            end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check("rand_rst_time_out", 64'(time_out), 64'd0);
                check("rand_rst_busy", 64'(busy), 64'd0);
                #2;
                rst = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
